// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 sequences into key events queued in a FWFT FIFO.
// Optional PS2_SHIFT_TRACK_EN adds o_shift (either shift key currently held).
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic [7:0] o_ev_code,
  output logic       o_ev_ext,
  output logic       o_ev_break,
  output logic       o_ev_valid,
  input  logic       i_ev_ready,
  output logic       o_bat_ok,
  output logic       o_err,
  output logic       o_overflow,
  input  logic       i_clr_ovf,
`ifdef PS2_SHIFT_TRACK_EN
  output logic       o_shift,
`endif
  output logic [2:0] o_dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t            state;
  logic [2:0]        skip_cnt;
  logic [TO_W-1:0]   timer;
  logic              ev_push;
  logic [9:0]        ev_word;   // {ext, brk, code}
  logic              is_special;

  // Handshake: the head transfers on any cycle where o_ev_valid && i_ev_ready;
  // the head is held unchanged while o_ev_valid && !i_ev_ready.
  logic [9:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop, full, wr;

  assign o_dbg_state = state;

  always_comb begin
    case (i_byte)
      8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE: is_special = 1'b1;
      default: is_special = 1'b0;
    endcase
  end

  always_comb begin
    ev_push = 1'b0;
    ev_word = {2'b00, i_byte};
    if (i_byte_valid) begin
      case (state)
        IDLE:    ev_push = !is_special;
        EXT: begin
          ev_push = (i_byte != 8'hF0) && (i_byte != 8'hE0);
          ev_word = {2'b10, i_byte};
        end
        BRK: begin
          ev_push = 1'b1;
          ev_word = {2'b01, i_byte};
        end
        EXT_BRK: begin
          ev_push = 1'b1;
          ev_word = {2'b11, i_byte};
        end
        PAUSE: begin
          ev_push = (skip_cnt == 3'd1);
          ev_word = {2'b10, 8'hE1};
        end
        default: ev_push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
      timer    <= '0;
      o_bat_ok <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_bat_ok <= 1'b0;
      o_err    <= 1'b0;
      if (i_byte_valid) begin
        // A byte always wins over a coincident timeout.
        timer <= '0;
        case (state)
          IDLE: begin
            case (i_byte)
              8'hE0: state <= EXT;
              8'hF0: state <= BRK;
              8'hE1: begin
                state    <= PAUSE;
                skip_cnt <= 3'd7;
              end
              8'hAA:        o_bat_ok <= 1'b1;
              8'h00, 8'hFF: o_err    <= 1'b1;
              default:      state    <= IDLE;
            endcase
          end
          EXT: begin
            if (i_byte == 8'hF0)      state <= EXT_BRK;
            else if (i_byte != 8'hE0) state <= IDLE;
          end
          PAUSE: begin
            if (skip_cnt == 3'd1) state <= IDLE;
            else                  skip_cnt <= skip_cnt - 3'd1;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timer == TO_LAST) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign pop  = (count != '0) && i_ev_ready;
  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign wr   = ev_push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= ev_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ev_push && full && !pop) o_overflow <= 1'b1;
      else if (i_clr_ovf)          o_overflow <= 1'b0;
    end
  end

  assign o_ev_valid = (count != '0);
  assign {o_ev_ext, o_ev_break, o_ev_code} = o_ev_valid ? mem[rd_ptr] : 10'd0;

`ifdef PS2_SHIFT_TRACK_EN
  logic l_shift, r_shift;

  // Tracks the decoded event, so a dropped (overflowed) event still updates it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      l_shift <= 1'b0;
      r_shift <= 1'b0;
    end else if (ev_push && !ev_word[9]) begin
      if (ev_word[7:0] == 8'h12) l_shift <= !ev_word[8];
      if (ev_word[7:0] == 8'h59) r_shift <= !ev_word[8];
    end
  end

  assign o_shift = l_shift | r_shift;
`endif

endmodule
